// File: rtl/mul_seq_if.sv
// Handshake and array-side bundle for the mul_seq sequencer.
// The slave modport is the sequencer; the master is issue logic plus the mul array.
interface mul_seq_if #(
    parameter int N = 64
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       op;
    logic [N/2-1:0]   src_a;
    logic [N/2-1:0]   src_b;
    logic             flush;
    logic [N/2-1:0]   mul_a;
    logic [N/2-1:0]   mul_b;
    logic [N-1:0]     mul_y;
    logic             resp_valid;
    logic             resp_ready;
    logic [N/2-1:0]   result;
    logic             busy;

    modport slave (
        input  req_valid, op, src_a, src_b, flush, mul_y, resp_ready,
        output req_ready, mul_a, mul_b, resp_valid, result, busy
    );

    modport master (
        output req_valid, op, src_a, src_b, flush, mul_y, resp_ready,
        input  req_ready, mul_a, mul_b, resp_valid, result, busy
    );
endinterface

// File: rtl/mul_seq.sv
// Multi-cycle sequencer around an unsigned N/2 x N/2 array multiplier.
// Applies RISC-V M signedness via operand magnitudes and product negation.
module mul_seq #(
    parameter int N           = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    mul_seq_if.slave   bus
);
    localparam int H = N / 2;
    localparam logic [H-1:0] ONE_H = {{(H-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};
    localparam logic [3:0]   CNT_INIT = 4'(WAIT_CYCLES - 1);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("mul_seq: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state_q;
    logic [3:0]   cnt_q;
    logic [H-1:0] mul_a_q;
    logic [H-1:0] mul_b_q;
    logic [H-1:0] result_q;
    logic         resp_valid_q;
    logic         neg_q;
    logic         hi_q;

    logic         a_neg;
    logic         b_neg;
    logic [H-1:0] mul_a_d;
    logic [H-1:0] mul_b_d;
    logic [N-1:0] prod_signed;
    logic [H-1:0] result_d;

    // MUL/MULH/MULHSU treat a as signed; only MUL/MULH treat b as signed.
    assign a_neg   = (bus.op != 2'b11) && bus.src_a[H-1];
    assign b_neg   = (bus.op[1] == 1'b0) && bus.src_b[H-1];
    assign mul_a_d = a_neg ? (~bus.src_a) + ONE_H : bus.src_a;
    assign mul_b_d = b_neg ? (~bus.src_b) + ONE_H : bus.src_b;

    assign prod_signed = neg_q ? (~bus.mul_y) + ONE_N : bus.mul_y;
    assign result_d    = hi_q ? prod_signed[N-1:H] : prod_signed[H-1:0];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            result_q     <= '0;
            resp_valid_q <= 1'b0;
            neg_q        <= 1'b0;
            hi_q         <= 1'b0;
        end else if (bus.flush) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        mul_a_q <= mul_a_d;
                        mul_b_q <= mul_b_d;
                        neg_q   <= a_neg ^ b_neg;
                        hi_q    <= (bus.op != 2'b00);
                        cnt_q   <= CNT_INIT;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    // mul_y is trusted only on this final settle edge.
                    if (cnt_q == 4'd0) begin
                        result_q     <= result_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE) && !bus.flush;
    assign bus.busy       = (state_q != IDLE);
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.result     = result_q;
    assign bus.resp_valid = resp_valid_q;
endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: vector table, scoreboard queue, and
// hand-written sequences for backpressure, flush and async reset.
module tb_mul_seq;
    localparam int N = 64;
    localparam int H = 32;
    localparam int W = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mul_seq_if #(.N(N)) bus ();

    mul_seq #(.N(N), .WAIT_CYCLES(W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int age = 100;
    bit prev_rv = 1'b0;
    logic [H-1:0] sb[$];

    // Array model: output is garbage until W-1 edges after new operands.
    logic [N-1:0] prod;
    assign prod = {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
    assign bus.mul_y = (age >= W - 1) ? prod : ~prod;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) age <= 100;
        else if (bus.req_valid && bus.req_ready) age <= 0;
        else if (age < 100) age <= age + 1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [H-1:0] model(input logic [1:0] o, input logic [H-1:0] a, input logic [H-1:0] b);
        logic [63:0] ea, eb, p;
        ea = (o != 2'b11 && a[H-1]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        eb = (o[1] == 1'b0 && b[H-1]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
        p = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Response monitor: latency, result compare, flush discard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.resp_valid && sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_resp: got resp_valid=1 result=%h expected no response", bus.result);
            end
            if (bus.resp_valid && !prev_rv && sb.size() > 0)
                check("latency", 64'(cyc - accept_cyc), 64'(W));
            if (bus.resp_valid && bus.resp_ready) begin
                if (sb.size() > 0) begin
                    logic [H-1:0] e;
                    e = sb.pop_front();
                    $display("resp result=%h exp=%h", bus.result, e);
                    check("result", 64'(bus.result), 64'(e));
                end
            end else if (bus.flush && bus.busy && sb.size() > 0) begin
                void'(sb.pop_front());
            end
        end
        prev_rv = bus.resp_valid;
    end

    task automatic issue(input logic [1:0] o, input logic [H-1:0] a, input logic [H-1:0] b, input logic [H-1:0] e);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.op = o;
        bus.src_a = a;
        bus.src_b = b;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            sb.push_back(e);
            accept_cyc = cyc + 1;
        end else begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1");
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 50; n++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_rv();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got resp_valid=0 expected 1");
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [H-1:0] a;
        logic [H-1:0] b;
        logic [H-1:0] exp;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [H-1:0] r0, a0, b0, ra, rb;
        logic [1:0] ro;

        tbl[0]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[1]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        tbl[2]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB};
        tbl[3]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF};
        tbl[4]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[5]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tbl[6]  = '{2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[7]  = '{2'b00, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A};
        tbl[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[9]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
        tbl[10] = '{2'b10, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0004};

        bus.req_valid  = 1'b0;
        bus.op         = 2'b00;
        bus.src_a      = '0;
        bus.src_b      = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_mul_a", 64'(bus.mul_a), 64'd0);
        check("rst_mul_b", 64'(bus.mul_b), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
            wait_drain();
        end

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            issue(ro, ra, rb, model(ro, ra, rb));
            wait_drain();
        end

        // Backpressure in DONE, then a request queued behind the handshake.
        bus.resp_ready = 1'b0;
        issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, model(2'b11, 32'h1234_5678, 32'h9ABC_DEF0));
        wait_rv();
        r0 = bus.result;
        a0 = bus.mul_a;
        b0 = bus.mul_b;
        repeat (5) begin
            @(negedge clk);
            check("bp_result", 64'(bus.result), 64'(r0));
            check("bp_req_ready", 64'(bus.req_ready), 64'd0);
            check("bp_mul_a", 64'(bus.mul_a), 64'(a0));
            check("bp_mul_b", 64'(bus.mul_b), 64'(b0));
            check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.op    = 2'b00;
        bus.src_a = 32'd6;
        bus.src_b = 32'd7;
        @(negedge clk);
        check("bp_done_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("bp_idle_req_ready", 64'(bus.req_ready), 64'd1);
        check("bp_idle_busy", 64'(bus.busy), 64'd0);
        sb.push_back(32'd42);
        accept_cyc = cyc + 1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("bp_next_busy", 64'(bus.busy), 64'd1);
        wait_drain();

        // Flush during SETTLE.
        issue(2'b00, 32'd1000, 32'd3, 32'd3000);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("fl_busy", 64'(bus.busy), 64'd0);
        repeat (W + 4) begin
            @(negedge clk);
            check("fl_no_resp", 64'(bus.resp_valid), 64'd0);
        end
        issue(2'b00, 32'd6, 32'd7, 32'd42);
        wait_drain();

        // Flush with a request in IDLE blocks acceptance.
        @(posedge clk); #1;
        bus.flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.op = 2'b11;
        bus.src_a = 32'd9;
        bus.src_b = 32'd9;
        @(negedge clk);
        check("fl_idle_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("fl_idle_busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset while holding a response in DONE.
        bus.resp_ready = 1'b0;
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_rv();
        #2 reset = 1'b1;
        #1;
        check("ar_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("ar_busy", 64'(bus.busy), 64'd0);
        check("ar_result", 64'(bus.result), 64'd0);
        sb.delete();
        #1 reset = 1'b0;
        bus.resp_ready = 1'b1;
        issue(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF);
        wait_drain();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle sequencer for the unsigned combinational array multiplier `mul` (N/2 × N/2 → N bits). It accepts multiply requests over a valid/ready handshake and applies RISC-V M-extension signedness by feeding operand magnitudes to the multiplier and negating the product. It holds the multiplier inputs stable for a programmable settle window, then returns the low or high half of the product. It sits between the execute-stage issue logic and the `mul` array. The array path is constrained as a multicycle path of `WAIT_CYCLES`.

## Interface
- `N`, 64, product width of the attached `mul`; operands and result are N/2 bits.
- `WAIT_CYCLES`, 2, settle cycles allowed for the array; legal range 1 to 15.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: combinational, equals (state==IDLE) && !flush.
- `op` in 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `src_a`, `src_b` in N/2: operands; `src_a` is signed for MUL/MULH/MULHSU, `src_b` is signed for MUL/MULH.
- `flush` in 1: abort the in-flight operation; no response is produced.
- `mul_a`, `mul_b` out N/2: registered operand magnitudes, wired to the `mul` a and b inputs.
- `mul_y` in N: unsigned product from `mul`.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts the result.
- `result` out N/2: registered result.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE: a request is accepted when `req_valid && req_ready`. On acceptance:
  - `mul_a` = |src_a| if src_a is signed for this op, else src_a. `mul_b` is formed the same way.
  - `neg` = sign(a)&a_signed ^ sign(b)&b_signed.
  - `hi` = op!=00.
  - `cnt` = WAIT_CYCLES-1.
  - Next state is SETTLE.
- Magnitude of the most negative value (0x8000_0000 for N=64) is 2^(N/2-1). It fits unsigned, so there is no special case.
- SETTLE: decrement `cnt` each cycle. When `cnt`==0:
  - p = neg ? (~mul_y + 1) mod 2^N : mul_y.
  - `result` = hi ? p[N-1:N/2] : p[N/2-1:0].
  - Next state is DONE.
- MUL ignores signedness for the low half. Because neg is computed from both signs, MUL still yields the correct two's-complement low word.
- DONE: `resp_valid`=1 and `result` is held stable. On `resp_ready`, go to IDLE. A new request is not accepted in the same cycle.
- `mul_a`/`mul_b` change only on acceptance. They hold through SETTLE and DONE, and hold their last values in IDLE.
- flush (any state): next state is IDLE, `resp_valid` is deasserted next cycle, and `result` is unchanged. A flush in IDLE blocks acceptance that cycle.
- flush and the `resp_ready` handshake in the same DONE cycle: the response counts as delivered. The consumer sampled `resp_valid`=1.
- Reset values: state IDLE, `cnt` 0, `mul_a`/`mul_b` 0, `result` 0, `resp_valid` 0, `busy` 0, neg/hi 0. `req_ready` is 1 whenever flush=0.
- Illegal WAIT_CYCLES (0 or >15) is rejected at elaboration.

## Timing
- Accept at edge E0 (req_valid && req_ready sampled high).
- SETTLE covers cycles E0..E0+WAIT_CYCLES-1.
- `result` and `resp_valid` update at edge E0+WAIT_CYCLES, so latency is WAIT_CYCLES cycles from acceptance to `resp_valid`.
- Minimum issue period is WAIT_CYCLES+2 cycles (DONE one cycle, IDLE one cycle).
- `mul_y` is sampled only at the final SETTLE edge. The `mul` array has WAIT_CYCLES cycles from the `mul_a`/`mul_b` register edge.
- The negation adder (N bits) lies on the last SETTLE cycle's path together with the array. It is part of the same multicycle budget.
- Reset asserted mid-operation: all state clears immediately and asynchronously. `resp_valid` drops without a clock edge.

## Test plan
- MULHU 0xFFFFFFFF×0xFFFFFFFF:
  - `resp_valid` rises exactly WAIT_CYCLES cycles after acceptance.
  - result = 0xFFFFFFFE.
  - Repeating with MUL gives 0x00000001.
- Signed ops on -3 (0xFFFFFFFD) and 7:
  - MUL → 0xFFFFFFEB.
  - MULH → 0xFFFFFFFF.
  - MULHSU with a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
  - MULH with 0x80000000×0x80000000 → 0x40000000.
- Zero with negative: MULH 0×0xFFFFFFFF → 0x00000000. This confirms -0 = 0 with no high-word leakage.
- Backpressure:
  - Hold `resp_ready`=0 for 5 cycles in DONE: `result` stays stable, `req_ready`=0, `mul_a`/`mul_b` unchanged.
  - On `resp_ready`=1, the state returns to IDLE and the next request is accepted one cycle later.
- Flush:
  - Assert flush during SETTLE: `resp_valid` never rises and `busy` drops next cycle.
  - A following MUL 6×7 returns 42 with normal latency.
  - Flush together with `req_valid` in IDLE: the request is not accepted.
- Async reset during DONE: `resp_valid`, `busy` and `result` go to 0 without a clock edge. The first request after release completes correctly.
